// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and default widths for the guessing game.
package game_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 4;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SHOW  = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/game_round_ctrl_if.sv
// game_round_ctrl_if: board I/O and answer BRAM signals of the round controller.
interface game_round_ctrl_if
  import game_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SCORE_W = 4
);
  logic              btn;
  logic [DATA_W-1:0] sw;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic              led_green;
  logic              led_red;
  logic [SCORE_W-1:0] score;
  logic [ADDR_W-1:0] round;
  logic              busy;
  logic              game_over;
  modport master (
    input  btn, sw, bram_dout,
    output bram_en, bram_addr, led_green, led_red, score, round, busy, game_over
  );
  modport slave (
    output btn, sw, bram_dout,
    input  bram_en, bram_addr, led_green, led_red, score, round, busy, game_over
  );
endinterface

// File: rtl/game_round_ctrl_btn_edge_detect.sv
// btn_edge_detect: one-cycle pulse on each rising edge of the debounced button.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  logic btn_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_i;
  end
  assign press_o = btn_i & ~btn_q;
endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: per-press guess capture, BRAM answer fetch, result display and scoring.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_ROUNDS  = 10,
  parameter int BRAM_LAT    = 1,
  parameter int RESULT_HOLD = 4,
  localparam int SCORE_W    = $clog2(NUM_ROUNDS + 1)
) (
  input logic clk,
  input logic rst,
  game_round_ctrl_if.master io
);
  localparam int CNT_MAX = (BRAM_LAT > RESULT_HOLD) ? BRAM_LAT : RESULT_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [DATA_W-1:0]  guess_q, guess_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               green_q, green_d, red_q, red_d;
  logic               press, match, last_round;
  btn_edge_detect u_edge (.clk(clk), .rst(rst), .btn_i(io.btn), .press_o(press));
  assign match      = io.bram_dout == guess_q;
  assign last_round = round_q == ADDR_W'(NUM_ROUNDS - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      score_q <= '0;
      guess_q <= '0;
      cnt_q   <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      score_q <= score_d;
      guess_q <= guess_d;
      cnt_q   <= cnt_d;
      green_q <= green_d;
      red_q   <= red_d;
    end
  end
  // cnt_q is shared: BRAM latency in WAIT, LED hold time in SHOW
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    score_d = score_q;
    guess_d = guess_q;
    green_d = green_q;
    red_d   = red_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: if (press) begin
        guess_d = io.sw;
        state_d = FETCH;
      end
      FETCH: state_d = WAIT;
      WAIT: if (cnt_q == CNT_W'(BRAM_LAT - 1)) begin
        green_d = match;
        red_d   = ~match;
        score_d = score_q + SCORE_W'(match);
        state_d = SHOW;
      end else cnt_d = cnt_q + 1'b1;
      SHOW: if (cnt_q == CNT_W'(RESULT_HOLD - 1)) begin
        green_d = 1'b0;
        red_d   = 1'b0;
        state_d = last_round ? DONE : IDLE;
        round_d = last_round ? round_q : round_q + 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      DONE: if (press) begin
        round_d = '0;
        score_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign io.bram_en   = state_q == FETCH;
  assign io.bram_addr = round_q;
  assign io.led_green = green_q | (state_q == DONE);
  assign io.led_red   = red_q | (state_q == DONE);
  assign io.score     = score_q;
  assign io.round     = round_q;
  assign io.busy      = state_q inside {FETCH, WAIT, SHOW};
  assign io.game_over = state_q == DONE;
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed rounds against a BRAM model with a result scoreboard.
module tb_game_round_ctrl;
  localparam int NR = 3;
  typedef struct {
    logic       green;
    logic [1:0] score;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] mem [16];
  exp_t q[$];
  int errors = 0, checks = 0, en_cnt = 0, exp_round = 0, exp_score = 0;
  game_round_ctrl_if #(.DATA_W(4), .ADDR_W(4), .SCORE_W(2)) gi ();
  game_round_ctrl #(.DATA_W(4), .ADDR_W(4), .NUM_ROUNDS(NR), .BRAM_LAT(1), .RESULT_HOLD(4))
    dut (.clk(clk), .rst(rst), .io(gi));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (gi.bram_en) begin
      gi.bram_dout <= mem[gi.bram_addr];
      en_cnt = en_cnt + 1;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // mode 0 plain, 1 sw changes after capture, 2 button held, 3 extra pulses mid-round
  task automatic drive(input int k, input int mode, input logic [3:0] g);
    gi.btn = (mode == 2) ? (k < 20) : (mode == 3) ? ((k % 2 == 1) && (k < 6)) : 1'b0;
    gi.sw  = (mode == 1) ? 4'h0 : g;
  endtask
  task automatic play(input logic [3:0] g, input int mode);
    exp_t e;
    int n, k, h, en0;
    logic bad;
    en0 = en_cnt;
    gi.sw = g;
    gi.btn = 1'b1;
    tick();
    k = 0;
    drive(k, mode, g);
    chk("fetch_en", 32'(gi.bram_en), 1);
    chk("fetch_addr", 32'(gi.bram_addr), exp_round);
    e.green = mem[exp_round] == g;
    exp_score += int'(e.green);
    e.score = 2'(exp_score);
    q.push_back(e);
    n = 0;
    while (!(gi.led_green | gi.led_red) && n < 12) begin
      tick(); k++; n++; drive(k, mode, g);
    end
    chk("led_latency", n, 2);
    e = q.pop_front();
    chk("led_green", 32'(gi.led_green), 32'(e.green));
    chk("led_red", 32'(gi.led_red), 32'(!e.green));
    chk("score", 32'(gi.score), 32'(e.score));
    h = 0;
    bad = 1'b0;
    while ((gi.led_green ^ gi.led_red) && h < 12) begin
      if (gi.led_green !== e.green) bad = 1'b1;
      tick(); k++; h++; drive(k, mode, g);
    end
    chk("led_hold", h, 4);
    chk("led_color_stable", 32'(bad), 0);
    while (k < 22) begin
      tick(); k++; drive(k, mode, g);
    end
    gi.btn = 1'b0;
    tick();
    chk("read_count", en_cnt - en0, 1);
    if (exp_round == NR - 1) begin
      chk("game_over", 32'(gi.game_over), 1);
      chk("done_leds", 32'({gi.led_green, gi.led_red}), 32'b11);
      chk("done_round", 32'(gi.round), exp_round);
    end else begin
      exp_round++;
      chk("round", 32'(gi.round), exp_round);
      chk("idle_busy", 32'(gi.busy), 0);
    end
  endtask
  task automatic restart();
    int en0;
    en0 = en_cnt;
    gi.btn = 1'b1;
    tick();
    gi.btn = 1'b0;
    exp_round = 0;
    exp_score = 0;
    chk("restart_score", 32'(gi.score), 0);
    chk("restart_round", 32'(gi.round), 0);
    chk("restart_over", 32'(gi.game_over), 0);
    chk("restart_leds", 32'({gi.led_green, gi.led_red}), 0);
    repeat (3) tick();
    chk("restart_no_read", en_cnt - en0, 0);
    chk("restart_busy", 32'(gi.busy), 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[0] = 4'h5;
    mem[1] = 4'hA;
    mem[2] = 4'h3;
    rst = 1'b1;
    gi.btn = 1'b0;
    gi.sw = 4'h0;
    tick();
    tick();
    chk("rst_outputs", 32'({gi.bram_en, gi.led_green, gi.led_red, gi.busy, gi.game_over}), 0);
    chk("rst_score_round", 32'({gi.score, gi.round, gi.bram_addr}), 0);
    rst = 1'b0;
    tick();
    play(4'h5, 0);
    play(4'h2, 0);
    play(4'h3, 0);
    repeat (5) tick();
    chk("done_hold_score", 32'(gi.score), 2);
    restart();
    play(4'h5, 2);
    play(4'hA, 3);
    play(4'h3, 1);
    restart();
    play(4'h5, 0);
    gi.sw = 4'hA;
    gi.btn = 1'b1;
    tick();
    gi.btn = 1'b0;
    repeat (3) tick();
    chk("pre_rst_led", 32'(gi.led_green), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_leds", 32'({gi.led_green, gi.led_red}), 0);
    chk("async_rst_score", 32'(gi.score), 0);
    chk("async_rst_round", 32'(gi.round), 0);
    chk("async_rst_busy", 32'(gi.busy), 0);
    tick();
    rst = 1'b0;
    exp_round = 0;
    exp_score = 0;
    q.delete();
    tick();
    play(4'h5, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
